pwm_multi_ch: RTL



---
 rtl/pwm_multi_ch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch
// Multi-channel PWM generator. One prescaler and one period counter are shared
// by all channels; each channel owns a double-buffered duty register whose
// active copy reloads only at the period wrap (or continuously while
// disabled), so outputs never glitch mid-period.
//
// Build option: define PWM_CENTER_ALIGN_EN for up/down (center-aligned)
// counting. Default build is edge-aligned only.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       run enable; low stops and clears the counters
//   prescale     tick divider, one tick every prescale+1 clk cycles
//   period       counter top value, period is period+1 ticks (edge-aligned)
//   wr_en        duty write strobe (one cycle)
//   wr_ch        channel index for the write (>= CH ignored)
//   wr_duty      new duty value in high-ticks per period
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse at each period wrap
// ---------------------------------------------------------------------------
module pwm_multi_ch #(
    parameter int CH  = 4,
    parameter int CW  = 8,
    parameter int PW  = 8,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [PW-1:0]  prescale,
    input  logic [CW-1:0]  period,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_duty,
    output logic [CH-1:0]  pwm_out,
    output logic           period_tick
);

    logic [PW-1:0] r_pcnt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_per_l;
    logic [CW-1:0] r_shd [CH];
    logic [CW-1:0] r_act [CH];
    logic [CH-1:0] r_pwm;
    logic          r_ptick;

    logic w_tick;
    logic w_wrap;
    logic w_wr_ok;

    assign w_tick  = enable && (r_pcnt == prescale);
    assign w_wr_ok = wr_en && (int'(wr_ch) < CH);

`ifdef PWM_CENTER_ALIGN_EN
    // 0 = counting up, 1 = counting down
    logic r_dir;

    assign w_wrap = w_tick && ((r_per_l == '0) || (r_dir && (r_cnt == '0)));
`else
    assign w_wrap = w_tick && (r_cnt == r_per_l);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd <= '{default: '0};
        end else if (w_wr_ok) begin
            r_shd[wr_ch] <= wr_duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt  <= '0;
            r_cnt   <= '0;
            r_per_l <= '0;
            r_act   <= '{default: '0};
            r_pwm   <= '0;
            r_ptick <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            r_dir   <= 1'b0;
`endif
        end else if (!enable) begin
            // Idle: keep the active copies tracking so re-enable starts fresh
            r_pcnt  <= '0;
            r_cnt   <= '0;
            r_per_l <= period;
            r_act   <= r_shd;
            r_pwm   <= '0;
            r_ptick <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            // >= so a prescale shrunk below the running count still wraps
            r_pcnt  <= (r_pcnt >= prescale) ? '0 : r_pcnt + 1'b1;
            r_ptick <= w_wrap;
            for (int i = 0; i < CH; i++) begin
                r_pwm[i] <= (r_cnt < r_act[i]);
            end
            if (w_wrap) begin
                r_per_l <= period;
                r_act   <= r_shd;
`ifdef PWM_CENTER_ALIGN_EN
                // The bottom cnt==0 slot is the wrap cycle itself, so the new
                // period resumes at 1 and lasts 2*per_l ticks.
                r_dir   <= 1'b0;
                r_cnt   <= (period == '0) ? '0 : CW'(1);
`else
                r_cnt   <= '0;
`endif
            end else if (w_tick) begin
`ifdef PWM_CENTER_ALIGN_EN
                if (!r_dir) begin
                    if (r_cnt == r_per_l) begin
                        r_dir <= 1'b1;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
`else
                r_cnt <= r_cnt + 1'b1;
`endif
            end
        end
    end

    assign pwm_out     = r_pwm;
    assign period_tick = r_ptick;

endmodule
